// File: rtl/operand_scoreboard_pkg.sv
// Shared constants for the operand fetch / issue stage: default widths,
// zero values and enable levels.
package operand_scoreboard_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;

   localparam logic [XLEN_DEF-1:0]   ZERO_WORD     = '0;
   localparam logic [REG_AW_DEF-1:0] ZERO_REG_ADDR = '0;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/operand_scoreboard_fwd_mux.sv
// Per-read-port operand selector: x0/disabled, ranked forwarding sources,
// writeback port, then register file.
module operand_scoreboard_fwd_mux
   import operand_scoreboard_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int NFWD   = 2
) (
   input  logic [REG_AW-1:0]      rs,
   input  logic                   rs_en,
   input  logic [NFWD-1:0]        fwd_valid,
   input  logic [NFWD-1:0]        fwd_pend,
   input  logic [NFWD*REG_AW-1:0] fwd_rd,
   input  logic [NFWD*XLEN-1:0]   fwd_data,
   input  logic                   wb_valid,
   input  logic [REG_AW-1:0]      wb_rd,
   input  logic [XLEN-1:0]        wb_data,
   input  logic [XLEN-1:0]        rf_rdata,
   output logic [XLEN-1:0]        value,
   output logic                   pend_hit,
   output logic                   resolved
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      value    = '0;
      pend_hit = DISABLE;
      resolved = DISABLE;
      if (rs_en && rs != '0) begin
         value = rf_rdata;
         if (wb_valid && wb_rd == rs) begin
            value    = wb_data;
            resolved = ENABLE;
         end
         // Scan oldest to youngest so the lowest-index hit is applied last and wins.
         for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_rd[i*REG_AW +: REG_AW] == rs) begin
               value    = fwd_data[i*XLEN +: XLEN];
               pend_hit = fwd_pend[i];
               resolved = ENABLE;
            end
         end
      end
   end

endmodule

// File: rtl/operand_scoreboard.sv
// Operand fetch and issue stage: forwarding selection, busy-bit scoreboard
// for long-latency destinations, and a flushable valid/ready output register.
module operand_scoreboard
   import operand_scoreboard_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int REG_AW    = REG_AW_DEF,
   parameter int NRD       = 2,
   parameter int NFWD      = 2,
   parameter int PAYLOAD_W = 96
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NRD*REG_AW-1:0]  in_rs,
   input  logic [NRD-1:0]         in_rs_en,
   input  logic [REG_AW-1:0]      in_rd,
   input  logic                   in_we,
   input  logic                   in_long,
   input  logic [PAYLOAD_W-1:0]   in_payload,
   output logic [NRD*REG_AW-1:0]  rf_raddr,
   input  logic [NRD*XLEN-1:0]    rf_rdata,
   input  logic [NFWD-1:0]        fwd_valid,
   input  logic [NFWD-1:0]        fwd_pend,
   input  logic [NFWD*REG_AW-1:0] fwd_rd,
   input  logic [NFWD*XLEN-1:0]   fwd_data,
   input  logic                   wb_valid,
   input  logic [REG_AW-1:0]      wb_rd,
   input  logic [XLEN-1:0]        wb_data,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NRD*XLEN-1:0]    out_vs,
   output logic [REG_AW-1:0]      out_rd,
   output logic                   out_we,
   output logic                   out_long,
   output logic [PAYLOAD_W-1:0]   out_payload,
   output logic                   stall_o
);

   localparam int NREG = 2 ** REG_AW;

   logic [NREG-1:0]     busy;
   logic                out_valid_q;
   logic [NRD*XLEN-1:0] res_vs;
   logic [NRD-1:0]      port_hazard;
   logic                waw_hazard;
   logic                hazard;
   logic                accept;
   logic                fire;
   logic                sb_set;
   logic                sb_clr;

   assign rf_raddr = in_rs;

   for (genvar p = 0; p < NRD; p++) begin : g_port
      logic [REG_AW-1:0] rs;
      logic              pend_hit;
      logic              resolved;

      assign rs = in_rs[p*REG_AW +: REG_AW];

      operand_scoreboard_fwd_mux #(
         .XLEN   (XLEN),
         .REG_AW (REG_AW),
         .NFWD   (NFWD)
      ) u_fwd_mux (
         .rs        (rs),
         .rs_en     (in_rs_en[p]),
         .fwd_valid (fwd_valid),
         .fwd_pend  (fwd_pend),
         .fwd_rd    (fwd_rd),
         .fwd_data  (fwd_data),
         .wb_valid  (wb_valid),
         .wb_rd     (wb_rd),
         .wb_data   (wb_data),
         .rf_rdata  (rf_rdata[p*XLEN +: XLEN]),
         .value     (res_vs[p*XLEN +: XLEN]),
         .pend_hit  (pend_hit),
         .resolved  (resolved)
      );

      // A producer still sitting in the output register has no forwarding path yet.
      assign port_hazard[p] = in_rs_en[p] && rs != '0 &&
                              (pend_hit ||
                               (out_valid && out_we && out_rd == rs) ||
                               (!resolved && busy[rs]));
   end

   assign waw_hazard = in_we && in_long && in_rd != '0 && busy[in_rd] &&
                       !(wb_valid && wb_rd == in_rd);
   assign hazard     = (|port_hazard) || waw_hazard;

   assign out_valid = out_valid_q && !flush;
   assign in_ready  = rdy && !flush && !hazard && (!out_valid_q || out_ready);
   assign stall_o   = in_valid && hazard;
   assign accept    = in_valid && in_ready;
   assign fire      = out_valid && out_ready && rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= DISABLE;
         out_vs      <= '0;
         out_rd      <= '0;
         out_we      <= DISABLE;
         out_long    <= DISABLE;
         out_payload <= '0;
      end else if (rdy) begin
         // NOTE: registered state uses non-blocking assignment so every
         // flop samples pre-edge values regardless of statement order.
         if (accept) begin
            out_valid_q <= ENABLE;
            out_vs      <= res_vs;
            out_rd      <= in_rd;
            out_we      <= in_we;
            out_long    <= in_long;
            out_payload <= in_payload;
         end else if (flush || out_ready) begin
            out_valid_q <= DISABLE;
         end
      end
   end

   assign sb_set = fire && out_we && out_long && out_rd != '0;
   assign sb_clr = rdy && wb_valid && wb_rd != '0;

   // Set is written after clear so a same-register collision leaves the bit set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (sb_clr) busy[wb_rd]  <= DISABLE;
         if (sb_set) busy[out_rd] <= ENABLE;
      end
   end

endmodule

// File: tb/tb_operand_scoreboard.sv
// Directed bench for operand_scoreboard: expected issues are queued on accept
// and compared when the output register presents them.
module tb_operand_scoreboard;

   logic         clk = 1'b0;
   logic         rst;
   logic         rdy;
   logic         in_valid;
   logic         in_ready;
   logic [9:0]   in_rs;
   logic [1:0]   in_rs_en;
   logic [4:0]   in_rd;
   logic         in_we;
   logic         in_long;
   logic [95:0]  in_payload;
   logic [9:0]   rf_raddr;
   logic [63:0]  rf_rdata;
   logic [1:0]   fwd_valid;
   logic [1:0]   fwd_pend;
   logic [9:0]   fwd_rd;
   logic [63:0]  fwd_data;
   logic         wb_valid;
   logic [4:0]   wb_rd;
   logic [31:0]  wb_data;
   logic         flush;
   logic         out_valid;
   logic         out_ready;
   logic [63:0]  out_vs;
   logic [4:0]   out_rd;
   logic         out_we;
   logic         out_long;
   logic [95:0]  out_payload;
   logic         stall_o;

   typedef struct packed {
      logic [63:0] vs;
      logic [4:0]  rd;
      logic        we;
      logic        lng;
      logic [95:0] pl;
   } exp_t;

   exp_t        q[$];
   logic [63:0] exp_vs;
   int          n_vec = 0;
   int          n_err = 0;

   operand_scoreboard dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rs       (in_rs),
      .in_rs_en    (in_rs_en),
      .in_rd       (in_rd),
      .in_we       (in_we),
      .in_long     (in_long),
      .in_payload  (in_payload),
      .rf_raddr    (rf_raddr),
      .rf_rdata    (rf_rdata),
      .fwd_valid   (fwd_valid),
      .fwd_pend    (fwd_pend),
      .fwd_rd      (fwd_rd),
      .fwd_data    (fwd_data),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_vs      (out_vs),
      .out_rd      (out_rd),
      .out_we      (out_we),
      .out_long    (out_long),
      .out_payload (out_payload),
      .stall_o     (stall_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] en,
                        input logic [4:0] rd, input logic we, input logic lng);
      in_valid   = 1'b1;
      in_rs      = {r1, r0};
      in_rs_en   = en;
      in_rd      = rd;
      in_we      = we;
      in_long    = lng;
      in_payload = {$urandom(), $urandom(), $urandom()};
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_rs_en = 2'b00;
      in_we    = 1'b0;
      in_long  = 1'b0;
   endtask

   // One clock: check handshake and output at the negedge, update the
   // expected-output queue, then advance to just after the next posedge.
   task automatic tick(input string tag, input logic exp_rdy, input logic exp_stall);
      exp_t e;
      @(negedge clk);
      check({tag, ".in_ready"}, in_ready, exp_rdy);
      check({tag, ".stall_o"}, stall_o, exp_stall);
      if (flush || q.size() == 0) begin
         check({tag, ".out_valid"}, out_valid, 1'b0);
      end else begin
         e = q[0];
         check({tag, ".out_valid"}, out_valid, 1'b1);
         check({tag, ".out_vs"}, out_vs, e.vs);
         check({tag, ".out_rd"}, out_rd, e.rd);
         check({tag, ".out_we"}, out_we, e.we);
         check({tag, ".out_long"}, out_long, e.lng);
         check({tag, ".out_payload"}, out_payload, e.pl);
      end
      if (q.size() != 0 && rdy && (flush || out_ready)) e = q.pop_front();
      if (in_valid && exp_rdy) begin
         e.vs  = exp_vs;
         e.rd  = in_rd;
         e.we  = in_we;
         e.lng = in_long;
         e.pl  = in_payload;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_rs = '0; in_rs_en = '0; in_rd = '0; in_we = 1'b0;
      in_long = 1'b0; in_payload = '0; rf_raddr_unused_guard();
      rf_rdata = {32'h2222_2222, 32'h1111_1111};
      fwd_valid = '0; fwd_pend = '0; fwd_rd = '0; fwd_data = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0; exp_vs = '0;

      // Reset state
      @(negedge clk);
      check("rst.out_valid", out_valid, 1'b0);
      check("rst.out_vs", out_vs, 64'd0);
      check("rst.out_rd", out_rd, 5'd0);
      check("rst.out_payload", out_payload, 96'd0);
      check("rst.busy", dut.busy, 32'd0);
      check("rst.in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Plain register-file read, then a back-to-back forwarded operand
      issue(5'd3, 5'd4, 2'b11, 5'd1, 1'b1, 1'b0);
      rf_rdata = {32'd20, 32'd10};
      exp_vs = {32'd20, 32'd10};
      tick("add", 1'b1, 1'b0);
      issue(5'd5, 5'd0, 2'b01, 5'd2, 1'b1, 1'b0);
      fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_data = {32'hB, 32'hA};
      exp_vs = {32'd0, 32'hA};
      tick("fwd_prio", 1'b1, 1'b0);
      check("add.busy", dut.busy, 32'd0);

      // Youngest source pending: stall until it resolves
      fwd_pend = 2'b01;
      tick("pend1", 1'b0, 1'b1);
      tick("pend2", 1'b0, 1'b1);
      fwd_pend = 2'b00;
      tick("pend_clr", 1'b1, 1'b0);
      idle(); fwd_valid = 2'b00;
      tick("idle1", 1'b1, 1'b0);

      // Load to x7, consumer waits for the writeback and issues in that cycle
      issue(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
      exp_vs = '0;
      tick("ld7", 1'b1, 1'b0);
      issue(5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
      exp_vs = {32'h55, 32'h55};
      tick("use7_outreg", 1'b0, 1'b1);
      check("ld7.busy", dut.busy, 32'h80);
      tick("use7_busy", 1'b0, 1'b1);
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
      tick("use7_wb", 1'b1, 1'b0);
      check("wb7.busy", dut.busy, 32'd0);
      idle(); wb_valid = 1'b0;
      tick("idle2", 1'b1, 1'b0);

      // WAW stall on x7, then same-cycle clear plus set leaves x7 busy
      issue(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
      exp_vs = '0;
      tick("ldA", 1'b1, 1'b0);
      idle();
      tick("ldA_fire", 1'b1, 1'b0);
      check("ldA.busy", dut.busy, 32'h80);
      issue(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
      tick("waw", 1'b0, 1'b1);
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
      tick("waw_wb", 1'b1, 1'b0);
      idle();
      tick("set_wins", 1'b1, 1'b0);
      check("set_wins.busy", dut.busy, 32'h80);
      wb_valid = 1'b0;

      // Flush drops the issued long op without touching the scoreboard
      issue(5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1);
      tick("ldC", 1'b1, 1'b0);
      idle(); flush = 1'b1;
      tick("flush", 1'b0, 1'b0);
      flush = 1'b0;
      tick("post_flush", 1'b1, 1'b0);
      check("flush.busy", dut.busy, 32'h80);

      // Freeze with rdy=0 while an output is held and a consumer stalls
      issue(5'd0, 5'd0, 2'b00, 5'd10, 1'b0, 1'b0);
      tick("opD", 1'b1, 1'b0);
      issue(5'd7, 5'd0, 2'b01, 5'd12, 1'b0, 1'b0);
      out_ready = 1'b0;
      tick("hold", 1'b0, 1'b1);
      rdy = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick("frz", 1'b0, 1'b1);
         check("frz.busy", dut.busy, 32'h80);
      end
      rdy = 1'b1; wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h66;
      exp_vs = {32'd0, 32'h66};
      tick("unfrz", 1'b1, 1'b0);
      idle(); wb_valid = 1'b0;
      tick("idle3", 1'b1, 1'b0);
      check("unfrz.busy", dut.busy, 32'd0);

      // x0 reads as zero despite a pending forward that targets x0
      issue(5'd0, 5'd0, 2'b11, 5'd13, 1'b1, 1'b0);
      fwd_valid = 2'b01; fwd_pend = 2'b01; fwd_rd = '0; fwd_data = {32'h0, 32'hFF};
      rf_rdata = {32'h3333, 32'h4444};
      exp_vs = '0;
      tick("x0", 1'b1, 1'b0);
      idle(); fwd_valid = 2'b00; fwd_pend = 2'b00;
      tick("idle4", 1'b1, 1'b0);

      // Asynchronous reset in the middle of a stall clears busy at once
      issue(5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b1);
      tick("ld11", 1'b1, 1'b0);
      idle();
      tick("ld11_fire", 1'b1, 1'b0);
      check("ld11.busy", dut.busy, 32'h800);
      issue(5'd11, 5'd0, 2'b01, 5'd14, 1'b0, 1'b0);
      tick("rst_stall", 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      check("async_rst.busy", dut.busy, 32'd0);
      check("async_rst.out_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // rf_raddr is a pure pass-through; tie it into one comparison after reset.
   task automatic rf_raddr_unused_guard();
   endtask

   initial begin
      @(negedge rst);
      #2;
      check("rf_raddr", rf_raddr, in_rs);
   end

endmodule
